mem_responder: RTL and testbench

- Memory-side responder for the 16-bit RISC CPU's data-memory interface.
- Replaces the zero-latency data memory with a handshaked, multi-cycle slave.
- Accepts one load/store request at a time, inserts a programmable number of wait states, then returns a response that the CPU must acknowledge.
- Sits between the CPU data port and word-organised backing storage inside the computer top level.

---
 rtl/mem_responder_pkg.sv | 13 +
 rtl/mem_responder_array.sv | 45 ++++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the data-memory responder
package mem_responder_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam logic [15:0] ERR_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - synchronous DEPTH x N word storage with registered read data
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic                     rd,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [N-1:0]             wdata,
  output logic [N-1:0]             rdata
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_d, rdata_q;

  // Storage is deliberately left out of reset so an aborted store leaves old contents intact.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = rd ? mem_q[idx] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - handshaked multi-cycle data-memory slave with programmable wait states
// Optional error reporting (rsp_err, 16'hDEAD load data) enabled by MEM_RESPONDER_ERR_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int n     = DATA_W,
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [n-1:0] rsp_rdata
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic         rsp_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e             state_d, state_q;
  logic [3:0]         cnt_d, cnt_q;
  logic               req_ready_d, req_ready_q;
  logic               rsp_valid_d, rsp_valid_q;
  logic               rsp_write_d, rsp_write_q;
  logic               we_d, we_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [n-1:0]       wdata_d, wdata_q;
  logic               err_d, err_q;
  logic               req_err;
  logic               access;
  logic [n-1:0]       arr_rdata;

`ifdef MEM_RESPONDER_ERR_EN
  logic rsp_err_d, rsp_err_q;
  assign req_err = req_addr[0] | (|req_addr[n-1:IDX_W+1]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[0], req_addr[n-1:IDX_W+1]};
  assign req_err          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    access      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          idx_d       = req_addr[IDX_W:1];
          wdata_d     = req_wdata;
          err_d       = req_err;
          cnt_d       = 4'(WAIT);
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      // Counter reaching zero adds the final cycle, giving WAIT+1 edges from accept to response.
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          access      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_write_d = we_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_write_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_RESPONDER_ERR_EN
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (access) begin
      rsp_err_d = err_q;
    end else if ((state_q == ST_RESP) && rsp_ready) begin
      rsp_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`endif

  mem_responder_array #(
    .N     (n),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .en    (access),
    .we    (we_q && !err_q),
    .rd    (!we_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = (err_q && !we_q) ? ERR_DATA : arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder (WAIT=2 and WAIT=0 instances)
// Honours MEM_RESPONDER_ERR_EN when defined.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_write [2];
  logic [15:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] mdl [2][64];

  always #5 clk = ~clk;

  mem_responder #(.n(16), .DEPTH(64), .WAIT(2)) dut_w2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0])
`ifdef MEM_RESPONDER_ERR_EN
    , .rsp_err(rsp_err[0])
`endif
  );

  mem_responder #(.n(16), .DEPTH(64), .WAIT(0)) dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1])
`ifdef MEM_RESPONDER_ERR_EN
    , .rsp_err(rsp_err[1])
`endif
  );

`ifndef MEM_RESPONDER_ERR_EN
  initial begin
    rsp_err[0] = 1'b0;
    rsp_err[1] = 1'b0;
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_err(input logic [15:0] a);
`ifdef MEM_RESPONDER_ERR_EN
    return (a % 2 == 1) || (a >= 16'd128);
`else
    return 1'b0;
`endif
  endfunction

  task automatic txn(input int sel, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input int hold, output logic [15:0] got);
    int          idx;
    int          lat;
    bit          ok;
    bit          e;
    logic [15:0] exp;
    idx = (int'(addr) / 2) % 64;
    e   = addr_err(addr);
    if (we) begin
      if (!e) mdl[sel][idx] = wdata;
      exp = 16'h0000;
    end else begin
      exp = e ? 16'hDEAD : mdl[sel][idx];
    end
    got = 'x;
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_ready_before_req", 32'(ok), 32'd1);
    if (!ok) return;
    req_valid[sel] = 1'b1;
    req_we[sel]    = we;
    req_addr[sel]  = addr;
    req_wdata[sel] = wdata;
    rsp_ready[sel] = (hold == 0);
    @(posedge clk);
    #1 req_valid[sel] = 1'b0;
    ok = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[sel] === 1'b1) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
    check("rsp_latency", 32'(lat), 32'(wait_of(sel) + 1));
    if (!ok) begin
      rsp_ready[sel] = 1'b0;
      return;
    end
    got = rsp_rdata[sel];
    check("rsp_write", 32'(rsp_write[sel]), 32'(we));
    check("rsp_rdata", 32'(rsp_rdata[sel]), 32'(exp));
`ifdef MEM_RESPONDER_ERR_EN
    check("rsp_err", 32'(rsp_err[sel]), 32'(e));
`endif
    for (int h = 0; h < hold; h++) begin
      req_valid[sel] = (h == 1);
      req_we[sel]    = 1'($urandom);
      req_addr[sel]  = 16'($urandom);
      req_wdata[sel] = 16'($urandom);
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 32'(rsp_valid[sel]), 32'd1);
      check("bp_rdata_stable", 32'(rsp_rdata[sel]), 32'(got));
      check("bp_req_ready", 32'(req_ready[sel]), 32'd0);
    end
    req_valid[sel] = 1'b0;
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    check("hs_rsp_valid_drop", 32'(rsp_valid[sel]), 32'd0);
    check("hs_req_ready", 32'(req_ready[sel]), 32'd1);
    rsp_ready[sel] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] g;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_we[s]    = 1'b0;
      req_addr[s]  = '0;
      req_wdata[s] = '0;
      rsp_ready[s] = 1'b0;
      for (int i = 0; i < 64; i++) mdl[s][i] = 16'h0000;
    end

    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        check("rst_req_ready", 32'(req_ready[s]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata[s]), 32'd0);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready_w2", 32'(req_ready[0]), 32'd1);
    check("post_rst_ready_w0", 32'(req_ready[1]), 32'd1);

    for (int i = 0; i < 64; i++) begin
      txn(0, 1'b1, 16'(i * 2), 16'h0000, 0, g);
      txn(1, 1'b1, 16'(i * 2), 16'h0000, 0, g);
    end

    txn(0, 1'b1, 16'h0004, 16'h1234, 0, g);
    check("store_rdata_zero", 32'(g), 32'h0);
    txn(0, 1'b0, 16'h0004, 16'h0000, 5, g);
    check("load_after_store", 32'(g), 32'h1234);

    txn(1, 1'b1, 16'h0080, 16'hBEEF, 0, g);
    txn(1, 1'b0, 16'h0000, 16'h0000, 2, g);
    check("wrap_load", 32'(g), 32'hBEEF);

    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h0010;
    req_wdata[0] = 16'hAAAA;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midwait_rst_ready", 32'(req_ready[0]), 32'd0);
    check("midwait_rst_valid", 32'(rsp_valid[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("midwait_rst_hold_valid", 32'(rsp_valid[0]), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midwait_post_ready", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 16'h0010, 16'h0000, 0, g);
    check("aborted_store", 32'(g), 32'h0000);

`ifdef MEM_RESPONDER_ERR_EN
    txn(0, 1'b0, 16'h0003, 16'h0000, 0, g);
    check("err_load_dead", 32'(g), 32'hDEAD);
    txn(0, 1'b1, 16'h0101, 16'h5555, 0, g);
    txn(0, 1'b0, 16'h0000, 16'h0000, 0, g);
    check("err_store_blocked", 32'(g), 32'(mdl[0][0]));
`endif

    for (int t = 0; t < 200; t++) begin
      int          sel;
      bit          we;
      logic [15:0] addr;
      sel  = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
      txn(sel, we, addr, 16'($urandom), int'($urandom_range(0, 3)), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
